// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - time-multiplexed scan controller for a common-digit
// 7-segment display bank.
//
// Steps through DIGITS slots of SCAN_DIV cycles each. Every slot starts with
// BLANK_CYCLES cycles with all digit enables off, which suppresses ghosting.
// After that only the enable for the current digit is asserted. New display
// data is staged in a shadow register and moves into the active register
// only at a frame boundary, so one frame never shows a mix of old and new
// values.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   load_i       1-cycle strobe that captures data_i / dp_i
//   data_i       BCD word, nibble k = digit k (digit 0 = least significant)
//   dp_i         decimal point per digit, 1 = lit
//   lz_blank_i   1 = suppress leading zeros
//   digit_data_o 4-bit code for the segment decoder, 4'hF = blank
//   dp_o         decimal point for the current digit, active-high
//   dig_sel_o    one-hot digit enable; active-low when DIG_ACTIVE_LOW = 1
//   frame_o      1-cycle pulse at each frame boundary
module seg_scan_ctrl #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter logic        DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lz_blank_i,
  output logic [3:0]            digit_data_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     dig_sel_o,
  output logic                  frame_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{DIG_ACTIVE_LOW}};

  // Scan position.
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Display data: active (currently scanned) and shadow (staged by load_i).
  logic [4*DIGITS-1:0] act_data_q, act_data_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                pend_q, pend_d;

  // Registered outputs.
  logic [3:0]          digit_data_q, digit_data_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_q, frame_d;

  // Helper signals.
  logic                div_wrap;
  logic                frame_wrap;
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   sel_onehot;
  logic [3:0]          cur_nib;
  logic                cur_dp;

  // Divider and digit index.
  always_comb begin
    div_wrap   = (div_q == DIV_LAST);
    frame_wrap = div_wrap && (idx_q == IDX_LAST);

    div_d = div_wrap ? '0 : div_q + 1'b1;

    idx_d = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow / active data handling. A load on the boundary edge bypasses the
  // shadow and goes straight to active, so it wins over older pending data.
  always_comb begin
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    pend_d     = pend_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;

    if (load_i) begin
      shd_data_d = data_i;
      shd_dp_d   = dp_i;
      pend_d     = 1'b1;
    end

    if (frame_wrap) begin
      pend_d = 1'b0;
      if (load_i) begin
        act_data_d = data_i;
        act_dp_d   = dp_i;
      end else if (pend_q) begin
        act_data_d = shd_data_q;
        act_dp_d   = shd_dp_q;
      end
    end
  end

  // Leading-zero mask. Walk from the most significant digit down. The run
  // of blankable digits ends at the first non-zero nibble or at the first
  // set decimal point. Digit 0 is never blanked.
  always_comb begin
    logic        run;
    int unsigned k;
    lz_mask = '0;
    run     = lz_blank_i;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      k   = DIGITS - 1 - j;
      run = run && (act_data_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
      lz_mask[k] = run && (k != 0);
    end
  end

  // Digit selected by the current index, with blanking applied.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib       = lz_mask[k] ? 4'hF : act_data_q[4*k +: 4];
        cur_dp        = act_dp_q[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  // Output registers. All outputs lag the counter by one cycle. Digit data
  // is latched only on the first cycle of a slot, which is also the first
  // blank cycle. Because of this the active register may change at the
  // frame boundary without disturbing the digit still on display.
  always_comb begin
    digit_data_d = digit_data_q;
    dp_d         = dp_q;
    if (div_q == '0) begin
      digit_data_d = cur_nib;
      dp_d         = cur_dp;
    end

    if (div_q >= BLANK_END) begin
      sel_d = sel_onehot ^ SEL_OFF;
    end else begin
      sel_d = SEL_OFF;
    end

    frame_d = frame_wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      pend_q       <= 1'b0;
      digit_data_q <= '0;
      dp_q         <= 1'b0;
      sel_q        <= SEL_OFF;
      frame_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      pend_q       <= pend_d;
      digit_data_q <= digit_data_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
      frame_q      <= frame_d;
    end
  end

  assign digit_data_o = digit_data_q;
  assign dp_o         = dp_q;
  assign dig_sel_o    = sel_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2,
// and active-low digit enables.
// Edge e counts rising edges after reset release. After edge e the outputs
// show div=(e-1)%8 and idx=((e-1)/8)%4. Frame boundaries fall on edges
// 32, 64, 96, and so on. Inside the frame that starts at boundary F, slot k
// is fully enabled on edges F+3+8k .. F+8+8k.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [3:0]  digit_data_o;
  logic        dp_o;
  logic [3:0]  dig_sel_o;
  logic        frame_o;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS        (4),
    .SCAN_DIV      (8),
    .BLANK_CYCLES  (2),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_i       (load_i),
    .data_i       (data_i),
    .dp_i         (dp_i),
    .lz_blank_i   (lz_blank_i),
    .digit_data_o (digit_data_o),
    .dp_o         (dp_o),
    .dig_sel_o    (dig_sel_o),
    .frame_o      (frame_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0h, expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go(input int n);
    while (e < n) tick();
  endtask

  // Load is held so that edge n captures it.
  task automatic load_at(input int n, input logic [15:0] d, input logic [3:0] p);
    go(n - 1);
    load_i = 1'b1;
    data_i = d;
    dp_i   = p;
    tick();
    load_i = 1'b0;
  endtask

  // Check one slot in the middle of its enabled window.
  task automatic slot(input string tag, input int f, input int k,
                      input logic [3:0] sel, input logic [3:0] nib, input logic dp);
    go(f + 5 + 8 * k);
    check({tag, "_sel"}, 32'(dig_sel_o), 32'(sel));
    check({tag, "_dat"}, 32'(digit_data_o), 32'(nib));
    check({tag, "_dp"},  32'(dp_o), 32'(dp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    load_i     = 1'b0;
    data_i     = 16'h0;
    dp_i       = 4'h0;
    lz_blank_i = 1'b0;
    tick();
    tick();
    check("rst_sel",   32'(dig_sel_o), 32'h0F);
    check("rst_dat",   32'(digit_data_o), 32'h0);
    check("rst_dp",    32'(dp_o), 32'h0);
    check("rst_frame", 32'(frame_o), 32'h0);
    rst_i = 1'b0;
    e = 0;

    // Slot timing after release, no load.
    go(1);  check("e1_sel", 32'(dig_sel_o), 32'hF);
    go(2);  check("e2_sel", 32'(dig_sel_o), 32'hF);
    go(3);  check("e3_sel", 32'(dig_sel_o), 32'hE);
            check("e3_dat", 32'(digit_data_o), 32'h0);
    go(8);  check("e8_sel", 32'(dig_sel_o), 32'hE);
    go(9);  check("e9_sel", 32'(dig_sel_o), 32'hF);
    go(10); check("e10_sel", 32'(dig_sel_o), 32'hF);
    go(11); check("e11_sel", 32'(dig_sel_o), 32'hD);
    go(27); check("e27_sel", 32'(dig_sel_o), 32'h7);
    go(31); check("e31_frame", 32'(frame_o), 32'h0);
    go(32); check("e32_frame", 32'(frame_o), 32'h1);
    go(33); check("e33_frame", 32'(frame_o), 32'h0);
            check("e33_sel", 32'(dig_sel_o), 32'hF);

    // Mid-frame load of 1234: the current frame still shows zeros.
    load_at(41, 16'h1234, 4'h0);
    slot("f1_s1", 32, 1, 4'hD, 4'h0, 1'b0);
    slot("f1_s3", 32, 3, 4'h7, 4'h0, 1'b0);
    go(63); check("e63_frame", 32'(frame_o), 32'h0);
    go(64); check("e64_frame", 32'(frame_o), 32'h1);
    slot("f2_s0", 64, 0, 4'hE, 4'h4, 1'b0);
    slot("f2_s1", 64, 1, 4'hD, 4'h3, 1'b0);
    slot("f2_s2", 64, 2, 4'hB, 4'h2, 1'b0);
    slot("f2_s3", 64, 3, 4'h7, 4'h1, 1'b0);

    // Two loads in one frame: the last one wins.
    load_at(100, 16'h1111, 4'h0);
    slot("f3_s0", 96, 0, 4'hE, 4'h4, 1'b0);
    load_at(110, 16'h2222, 4'h0);
    slot("f4_s0", 128, 0, 4'hE, 4'h2, 1'b0);
    slot("f4_s3", 128, 3, 4'h7, 4'h2, 1'b0);

    // A load on the boundary edge goes straight to active.
    load_at(160, 16'h5678, 4'h0);
    check("e160_frame", 32'(frame_o), 32'h1);
    slot("f5_s0", 160, 0, 4'hE, 4'h8, 1'b0);
    slot("f5_s1", 160, 1, 4'hD, 4'h7, 1'b0);
    slot("f5_s2", 160, 2, 4'hB, 4'h6, 1'b0);
    slot("f5_s3", 160, 3, 4'h7, 4'h5, 1'b0);

    // Leading-zero blanking.
    lz_blank_i = 1'b1;
    load_at(190, 16'h0070, 4'h0);
    slot("lz70_s0", 192, 0, 4'hE, 4'h0, 1'b0);
    slot("lz70_s1", 192, 1, 4'hD, 4'h7, 1'b0);
    slot("lz70_s2", 192, 2, 4'hB, 4'hF, 1'b0);
    slot("lz70_s3", 192, 3, 4'h7, 4'hF, 1'b0);

    load_at(222, 16'h0000, 4'h0);
    slot("lz00_s0", 224, 0, 4'hE, 4'h0, 1'b0);
    slot("lz00_s1", 224, 1, 4'hD, 4'hF, 1'b0);
    slot("lz00_s2", 224, 2, 4'hB, 4'hF, 1'b0);
    slot("lz00_s3", 224, 3, 4'h7, 4'hF, 1'b0);

    load_at(254, 16'h0000, 4'b0100);
    slot("lzdp_s0", 256, 0, 4'hE, 4'h0, 1'b0);
    slot("lzdp_s1", 256, 1, 4'hD, 4'h0, 1'b0);
    slot("lzdp_s2", 256, 2, 4'hB, 4'h0, 1'b1);
    slot("lzdp_s3", 256, 3, 4'h7, 4'hF, 1'b0);

    // Reset during slot 2 with a load pending.
    lz_blank_i = 1'b0;
    load_at(298, 16'h9999, 4'hF);
    go(307);
    rst_i = 1'b1;
    tick();
    check("mrst_sel",   32'(dig_sel_o), 32'hF);
    check("mrst_dat",   32'(digit_data_o), 32'h0);
    check("mrst_dp",    32'(dp_o), 32'h0);
    check("mrst_frame", 32'(frame_o), 32'h0);
    rst_i = 1'b0;
    e = 0;
    go(2);  check("r2_sel", 32'(dig_sel_o), 32'hF);
    go(3);  check("r3_sel", 32'(dig_sel_o), 32'hE);
            check("r3_dat", 32'(digit_data_o), 32'h0);
    go(32); check("r32_frame", 32'(frame_o), 32'h1);
    // The discarded pending load must not reach the display.
    slot("rf1_s0", 32, 0, 4'hE, 4'h0, 1'b0);
    slot("rf1_s3", 32, 3, 4'h7, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
